// File: rtl/aib_axi_pkg.sv
// Shared types and defaults for the AIB link bring-up logic.
// Holds the state encoding, the parameter defaults and a small saturating-increment helper.
package aib_axi_pkg;

  localparam int NBR_CHNLS_DEF    = 24;
  localparam int ACTIVE_CHNLS_DEF = 1;
  localparam int RST_HOLD_CYC_DEF = 16;
  localparam int TIMEOUT_CYC_DEF  = 65535;
  localparam int MAX_RETRY_DEF    = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_DETECT = 3'd1,
    ST_ADAPT_RST   = 3'd2,
    ST_WAIT_XFER   = 3'd3,
    ST_WAIT_ALIGN  = 3'd4,
    ST_LINK_UP     = 3'd5,
    ST_ERROR       = 3'd6
  } link_state_e;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage

// File: rtl/aib_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous status inputs.
// Both stages clear on reset so no stale status leaks into a new bring-up.
module aib_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Two-stage capture of the asynchronous vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/aib_link_bringup_fsm.sv
// AIB link bring-up sequencer: adapter reset, transfer-enable and alignment handshakes,
// bounded retries, and a registered link_up that drives the AXI bridge online controls.
module aib_link_bringup_fsm
  import aib_axi_pkg::*;
#(
  parameter int NBR_CHNLS    = NBR_CHNLS_DEF,
  parameter int ACTIVE_CHNLS = ACTIVE_CHNLS_DEF,
  parameter int RST_HOLD_CYC = RST_HOLD_CYC_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 i_enable,
  input  logic                 i_conf_done,
  input  logic                 m_device_detect,
  input  logic [NBR_CHNLS-1:0] ms_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] sl_tx_transfer_en,
  input  logic [NBR_CHNLS-1:0] m_rx_align_done,
  input  logic [NBR_CHNLS-1:0] fs_mac_rdy,
  output logic [NBR_CHNLS-1:0] ns_adapter_rstn,
  output logic [NBR_CHNLS-1:0] ns_mac_rdy,
  output logic [NBR_CHNLS-1:0] sl_rx_dcc_dll_lock_req,
  output logic [NBR_CHNLS-1:0] sl_tx_dcc_dll_lock_req,
  output logic                 link_up,
  output logic                 link_err,
  output logic [2:0]           o_state,
  output logic [1:0]           o_retry_cnt
);

  localparam logic [NBR_CHNLS-1:0] ACT_MASK  = NBR_CHNLS'((64'd1 << ACTIVE_CHNLS) - 64'd1);
  localparam logic [15:0]          HOLD_LAST = 16'(RST_HOLD_CYC - 1);
  localparam logic [15:0]          TO_LAST   = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]           RETRY_LIM = 2'(MAX_RETRY);

  logic                 detect_s;
  logic [NBR_CHNLS-1:0] ms_xfer_s, sl_xfer_s, align_s, rdy_s;
  logic                 xfer_up_s, align_up_s, rdy_up_s;
  logic                 unused_s;

  link_state_e          state_r, state_nxt;
  logic [15:0]          cnt_r, cnt_nxt;
  logic [1:0]           retry_r, retry_nxt;
  logic [NBR_CHNLS-1:0] ctrl_r, ctrl_nxt;
  logic                 link_up_r, link_err_r;
  logic                 fail_s;

  aib_sync2 #(.WIDTH(1))         u_sync_det   (.clk(clk_wr), .rst_n(rst_wr_n), .d(m_device_detect),   .q(detect_s));
  aib_sync2 #(.WIDTH(NBR_CHNLS)) u_sync_msx   (.clk(clk_wr), .rst_n(rst_wr_n), .d(ms_tx_transfer_en), .q(ms_xfer_s));
  aib_sync2 #(.WIDTH(NBR_CHNLS)) u_sync_slx   (.clk(clk_wr), .rst_n(rst_wr_n), .d(sl_tx_transfer_en), .q(sl_xfer_s));
  aib_sync2 #(.WIDTH(NBR_CHNLS)) u_sync_align (.clk(clk_wr), .rst_n(rst_wr_n), .d(m_rx_align_done),   .q(align_s));
  aib_sync2 #(.WIDTH(NBR_CHNLS)) u_sync_rdy   (.clk(clk_wr), .rst_n(rst_wr_n), .d(fs_mac_rdy),        .q(rdy_s));

  // Only the active channels take part; the inactive upper bits are deliberately ignored.
  assign xfer_up_s  = &(ms_xfer_s[ACTIVE_CHNLS-1:0]) & &(sl_xfer_s[ACTIVE_CHNLS-1:0]);
  assign align_up_s = &(align_s[ACTIVE_CHNLS-1:0]) & &(rdy_s[ACTIVE_CHNLS-1:0]);
  assign rdy_up_s   = &(rdy_s[ACTIVE_CHNLS-1:0]);
  assign unused_s   = &{1'b0, ms_xfer_s, sl_xfer_s, align_s, rdy_s};

  // Next-state, retry and registered-output decode.
  always_comb begin
    state_nxt = state_r;
    retry_nxt = retry_r;
    fail_s    = 1'b0;
    if (!i_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:        if (i_conf_done) state_nxt = ST_WAIT_DETECT; else state_nxt = ST_IDLE;
        ST_WAIT_DETECT: if (detect_s) state_nxt = ST_ADAPT_RST; else state_nxt = ST_WAIT_DETECT;
        ST_ADAPT_RST:   if (cnt_r == HOLD_LAST) state_nxt = ST_WAIT_XFER; else state_nxt = ST_ADAPT_RST;
        // Success is tested before the timeout so a coincident success wins.
        ST_WAIT_XFER:   if (xfer_up_s) state_nxt = ST_WAIT_ALIGN; else if (cnt_r == TO_LAST) fail_s = 1'b1; else state_nxt = ST_WAIT_XFER;
        ST_WAIT_ALIGN:  if (align_up_s) state_nxt = ST_LINK_UP; else if (cnt_r == TO_LAST) fail_s = 1'b1; else state_nxt = ST_WAIT_ALIGN;
        ST_LINK_UP:     if (!(xfer_up_s && rdy_up_s)) fail_s = 1'b1; else state_nxt = ST_LINK_UP;
        ST_ERROR:       state_nxt = ST_ERROR;
        default:        state_nxt = ST_IDLE;
      endcase
      if (fail_s) begin
        retry_nxt = sat_inc2(retry_r);
        state_nxt = (retry_nxt == RETRY_LIM) ? ST_ERROR : ST_ADAPT_RST;
      end else begin
        retry_nxt = retry_r;
      end
    end

    if (state_nxt == ST_IDLE || state_nxt == ST_LINK_UP) begin
      retry_nxt = 2'd0;
    end else begin
      retry_nxt = retry_nxt;
    end

    if (state_nxt != state_r) begin
      cnt_nxt = 16'd0;
    end else if (cnt_r != 16'hFFFF) begin
      cnt_nxt = cnt_r + 16'd1;
    end else begin
      cnt_nxt = cnt_r;
    end

    if (state_nxt == ST_WAIT_XFER || state_nxt == ST_WAIT_ALIGN || state_nxt == ST_LINK_UP) begin
      ctrl_nxt = ACT_MASK;
    end else begin
      ctrl_nxt = '0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 16'd0;
      retry_r    <= 2'd0;
      ctrl_r     <= '0;
      link_up_r  <= 1'b0;
      link_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cnt_r      <= cnt_nxt;
      retry_r    <= retry_nxt;
      ctrl_r     <= ctrl_nxt;
      link_up_r  <= (state_nxt == ST_LINK_UP);
      link_err_r <= (state_nxt == ST_ERROR);
    end
  end

  assign ns_adapter_rstn        = ctrl_r;
  assign ns_mac_rdy             = ctrl_r;
  assign sl_rx_dcc_dll_lock_req = ctrl_r;
  assign sl_tx_dcc_dll_lock_req = ctrl_r;
  assign link_up                = link_up_r;
  assign link_err               = link_err_r;
  assign o_state                = state_r;
  assign o_retry_cnt            = retry_r;

endmodule
